// File: rtl/div_iter_if.sv
// EX-stage divider request/response bundle: operands and control from EX,
// packed {remainder, quotient} result plus ready/stall back to the pipeline.
interface div_iter_if #(
  parameter int DW = 32
);
  logic              start;
  logic              signed_div;
  logic [DW-1:0]     opdata1;
  logic [DW-1:0]     opdata2;
  logic              annul;
  logic [2*DW-1:0]   result;
  logic              ready;
  logic              stall;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on
// magnitudes, signs applied at the end; result packed {remainder, quotient}.
module div_iter #(
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);
  localparam int CW = $clog2(DW);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] BUSY    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [DW-1:0]    rem_reg;
  logic [DW-1:0]    quo_reg;
  logic [DW-1:0]    dvs_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [2*DW-1:0]  result_reg;

  logic             accept;
  logic [DW-1:0]    a_abs;
  logic [DW-1:0]    b_abs;
  logic [DW:0]      rem_sh;
  logic [DW:0]      diff;
  logic [DW-1:0]    rem_step;
  logic [DW-1:0]    quo_step;
  logic [DW-1:0]    rem_fin;
  logic [DW-1:0]    quo_fin;

  assign accept = (state_reg == IDLE) && bus.start && !bus.annul;

  always_comb begin
    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    a_abs = (bus.signed_div && bus.opdata1[DW-1]) ? -bus.opdata1 : bus.opdata1;
    b_abs = (bus.signed_div && bus.opdata2[DW-1]) ? -bus.opdata2 : bus.opdata2;

    // Shifted remainder needs DW+1 bits; the difference's top bit is the borrow.
    rem_sh   = {rem_reg, quo_reg[DW-1]};
    diff     = rem_sh - {1'b0, dvs_reg};
    rem_step = diff[DW] ? rem_sh[DW-1:0] : diff[DW-1:0];
    quo_step = {quo_reg[DW-2:0], ~diff[DW]};
    quo_fin  = neg_q_reg ? -quo_step : quo_step;
    rem_fin  = neg_r_reg ? -rem_step : rem_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            dvs_reg   <= b_abs;
            neg_q_reg <= bus.signed_div & (bus.opdata1[DW-1] ^ bus.opdata2[DW-1]);
            neg_r_reg <= bus.signed_div & bus.opdata1[DW-1];
            rem_reg   <= '0;
            cnt_reg   <= '0;
            if (bus.opdata2 == '0) begin
              // Divide-by-zero returns the raw dividend as remainder, so keep it unmodified.
              quo_reg   <= bus.opdata1;
              state_reg <= DIVZERO;
            end else begin
              quo_reg   <= a_abs;
              state_reg <= BUSY;
            end
          end
        end
        DIVZERO: begin
          if (bus.annul) begin
            state_reg <= IDLE;
          end else begin
            result_reg <= {quo_reg, {DW{1'b1}}};
            state_reg  <= DONE;
          end
        end
        BUSY: begin
          if (bus.annul) begin
            state_reg <= IDLE;
          end else begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(DW - 1)) begin
              result_reg <= {rem_fin, quo_fin};
              state_reg  <= DONE;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.result = result_reg;
  assign bus.ready  = (state_reg == DONE);
  assign bus.stall  = accept || (state_reg == DIVZERO) || (state_reg == BUSY);
endmodule

// File: tb/tb_div_iter.sv
// Directed checks of div_iter: expected results queued at issue, popped and
// compared (value and arrival cycle) by an independent monitor on ready.
module tb_div_iter;
  localparam int DW = 32;

  typedef struct {
    logic [2*DW-1:0] res;
    int              cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  logic [2*DW-1:0] last_res;

  div_iter_if #(.DW(DW)) bus ();

  div_iter #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.ready) begin
      exp_t e;
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_ready: cycle %0d result %h, no result expected", cyc, bus.result);
      end else begin
        e = sb_q.pop_front();
        if (bus.result !== e.res || cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL result: got %h at cycle %0d, expected %h at cycle %0d",
                   bus.result, cyc, e.res, e.cyc);
        end else begin
          $display("txn ok: result %h at cycle %0d", bus.result, cyc);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Issue one divide, hold start until ready, scramble operands mid-flight.
  task automatic run_div(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2*DW-1:0] expv, input int lat);
    exp_t e;
    bit   done;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    e.res = expv;
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    $display("issue: %s %h / %h at cycle %0d", sgn ? "DIV " : "DIVU", a, b, cyc);
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        check1("stall_in_done", {63'd0, bus.stall}, 64'd0);
        done = 1;
      end else begin
        check1("stall_while_busy", {63'd0, bus.stall}, 64'd1);
      end
      if (k == 4) begin
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = ~sgn;
      end
    end
    if (!done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL timeout: no ready within 60 cycles, expected %h", expv);
      void'(sb_q.pop_front());
    end
    last_res = expv;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset_result", bus.result, 64'd0);
    check1("reset_ready", {63'd0, bus.ready}, 64'd0);
    check1("reset_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div(1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},               33);
    run_div(1'b1, 32'hFFFFFFF9,   32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33);
    run_div(1'b1, 32'h7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD},  33);
    run_div(1'b0, 32'h12345678,   32'h0,        {32'h12345678, 32'hFFFFFFFF},  2);
    run_div(1'b1, 32'h80000000,   32'h0,        {32'h80000000, 32'hFFFFFFFF},  2);
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000},  33);
    run_div(1'b0, 32'hFFFFFFFF,   32'h1,        {32'h00000000, 32'hFFFFFFFF},  33);
    run_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E},  33);
    run_div(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'h00000000, 32'h00000001},  33);
    run_div(1'b0, 32'd5,          32'd9,        {32'd5, 32'd0},                33);

    // Annul at cnt=10: back to IDLE, no ready, result untouched.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    @(negedge clk);
    check1("annul_stall", {63'd0, bus.stall}, 64'd0);
    check1("annul_ready", {63'd0, bus.ready}, 64'd0);
    repeat (40) @(negedge clk);
    check1("annul_result_kept", bus.result, last_res);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Reset mid-BUSY.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd50; bus.opdata2 = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("midreset_ready", {63'd0, bus.ready}, 64'd0);
    check1("midreset_stall", {63'd0, bus.stall}, 64'd0);
    check1("midreset_result", bus.result, 64'd0);
    run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

    repeat (5) @(negedge clk);
    check1("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
- Replaces a single-cycle combinational divide path.
- Takes the two EX operands and stalls the pipeline while it iterates.
- Returns {remainder, quotient} packed as {hi, lo}, the same 64-bit layout the EX result bus delivers to the HI/LO register write.

Parameters:
- DW, 32, operand width; quotient and remainder are each DW bits, result is 2*DW.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a divide; held high by EX for as long as the div instruction sits in EX
- signed_div  in  1  1 = DIV (signed), 0 = DIVU
- opdata1  in  DW  dividend (rs)
- opdata2  in  DW  divisor (rt)
- annul  in  1  flush (exception/branch kill); abort any operation in flight
- result  out  2*DW  {remainder, quotient}
- ready  out  1  one-cycle pulse: result valid this cycle
- stall  out  1  hold the pipeline

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, result=0, ready=0. stall=0 unless start is high while in IDLE.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE, start=1, annul=0:
  - Latch operands and signed_div.
  - Signed mode: latch absolute values, plus sign flags neg_q = a[DW-1]^b[DW-1] and neg_r = a[DW-1].
  - Go to DIVZERO if divisor==0, else BUSY with cnt=0 and partial remainder=0.
- BUSY, one quotient bit per cycle, MSB first:
  - Shift {rem, dividend} left 1.
  - Trial-subtract |divisor|. If the result is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - cnt increments. After DW iterations, go to DONE.
- DIVZERO: go to DONE next cycle. Result is quotient = all ones, remainder = original dividend, independent of sign mode.
- DONE:
  - Signed mode: quotient negated if neg_q; remainder negated if neg_r. This gives truncating division, and the remainder takes the dividend's sign.
  - Register result, ready=1 for exactly this cycle, then go to IDLE.
  - start is ignored in DONE (it is still the same instruction).
- Latency, counted from the start cycle T:
  - normal: ready at T+DW+1 (T+33 for DW=32)
  - divide-by-zero: ready at T+2
- stall = (state==IDLE && start && !annul) || state==DIVZERO || state==BUSY. stall=0 in DONE so EX advances and captures result that cycle.
- result holds its value after DONE until the next completion. It is never modified by an annulled operation.
- annul=1 in any state other than IDLE: go to IDLE on the next edge, no ready pulse, stall drops. annul overrides start in IDLE.
- rst mid-operation: return to reset values immediately on that edge.
- start while BUSY/DIVZERO: ignored. Operands are taken only at acceptance; later input changes have no effect.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0. No trap.
- Widths:
  - Absolute value of 0x80000000 is 0x80000000 treated as unsigned.
  - Trial subtraction uses a DW+1-bit difference; its sign bit is the borrow.

Test Plan:
- DIVU 100/7, start at T -> stall high T..T+32, ready at T+33, result={32'd2, 32'd14}.
- DIV -7/2 (0xFFFFFFF9, 0x2) -> result={0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- DIVU 0x12345678/0 -> ready at T+2, result={0x12345678, 0xFFFFFFFF}.
- DIV 0x80000000/0xFFFFFFFF -> result={0x00000000, 0x80000000}. DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- annul at BUSY cnt=10 -> IDLE next cycle, no ready, result unchanged. A new DIVU 9/3 then returns {0, 3} 33 cycles after its start.
- rst asserted mid-BUSY -> next cycle ready=0, stall=0, result=0. Operands changed during BUSY -> result unaffected.
